sram_dp_be: RTL and testbench

Parametrised two-read/one-write internal SRAM with byte write strobes, write-first collision forwarding, an optional output register stage, and a hardware clear sequence after reset. It replaces the fixed 32-bit scratch memory wherever the core or peripherals need partial-word stores, wider or narrower words, or known-zero contents after reset. It provides per-port read-valid strobes, so consumers do not need to track the configured read latency.

---
 rtl/sram_dp_be.sv | 132 +++++++++++++
 tb/tb_sram_dp_be.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_be.sv
// sram_dp_be: two-read/one-write SRAM with byte strobes, write-first forwarding,
// an optional output register stage and a zero-fill sequence after reset.
module sram_dp_be #(
    parameter int word_size    = 32,
    parameter int num_words    = 4096,
    parameter int l2_num_words = 12,
    parameter int out_reg      = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    output logic                      o_ready,
    input  logic                      i_read_enable_A,
    input  logic [l2_num_words-1:0]   i_addr_read_A,
    output logic [word_size-1:0]      o_data_read_A,
    output logic                      o_valid_A,
    input  logic                      i_read_enable_B,
    input  logic [l2_num_words-1:0]   i_addr_read_B,
    output logic [word_size-1:0]      o_data_read_B,
    output logic                      o_valid_B,
    input  logic                      i_write_enable,
    input  logic [word_size/8-1:0]    i_write_strb,
    input  logic [l2_num_words-1:0]   i_addr_write,
    input  logic [word_size-1:0]      i_data_to_write
);
    localparam int nb = word_size / 8;
    localparam logic [l2_num_words:0]   depth = (l2_num_words + 1)'(num_words);
    localparam logic [l2_num_words-1:0] last  = l2_num_words'(num_words - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    logic [l2_num_words-1:0] count;
    logic                    ready;
    logic [word_size-1:0]    mem [num_words];

    function automatic logic [word_size-1:0] merge(input logic [word_size-1:0] old,
                                                   input logic [word_size-1:0] data,
                                                   input logic [nb-1:0] strb);
        logic [word_size-1:0] r;
        r = old;
        for (int k = 0; k < nb; k++)
            if (strb[k]) r[8*k +: 8] = data[8*k +: 8];
        return r;
    endfunction

    logic                    clearing, wr_ok, rd_a, rd_b, in_a, in_b;
    logic                    mem_we;
    logic [l2_num_words-1:0] mem_addr;
    logic [word_size-1:0]    mem_data, old_a, old_b, word_a, word_b;
    logic [nb-1:0]           mem_strb;

    assign clearing = state == CLEAR;
    assign wr_ok    = ready && i_write_enable && ({1'b0, i_addr_write} < depth);
    assign rd_a     = ready && i_read_enable_A;
    assign rd_b     = ready && i_read_enable_B;
    assign in_a     = {1'b0, i_addr_read_A} < depth;
    assign in_b     = {1'b0, i_addr_read_B} < depth;

    // Out-of-range reads can never match an accepted (in-range) write address.
    assign old_a  = in_a ? mem[i_addr_read_A] : '0;
    assign old_b  = in_b ? mem[i_addr_read_B] : '0;
    assign word_a = (wr_ok && i_addr_read_A == i_addr_write) ? merge(old_a, i_data_to_write, i_write_strb) : old_a;
    assign word_b = (wr_ok && i_addr_read_B == i_addr_write) ? merge(old_b, i_data_to_write, i_write_strb) : old_b;

    assign mem_we   = clearing || wr_ok;
    assign mem_addr = clearing ? count : i_addr_write;
    assign mem_data = clearing ? '0 : i_data_to_write;
    assign mem_strb = clearing ? '1 : i_write_strb;

    always_ff @(posedge i_clk)
        for (int k = 0; k < nb; k++)
            if (mem_we && mem_strb[k]) mem[mem_addr][8*k +: 8] <= mem_data[8*k +: 8];

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state <= CLEAR;
            count <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            count <= count + 1'b1;
            if (count == last) begin
                state <= READY;
                ready <= 1'b1;
            end
        end

    assign o_ready = ready;

    logic                 v1_a, v1_b;
    logic [word_size-1:0] d1_a, d1_b;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            v1_a <= 1'b0;
            v1_b <= 1'b0;
            d1_a <= '0;
            d1_b <= '0;
        end else begin
            v1_a <= rd_a;
            v1_b <= rd_b;
            if (rd_a) d1_a <= word_a;
            if (rd_b) d1_b <= word_b;
        end

    generate
        if (out_reg != 0) begin : g_out
            logic                 v2_a, v2_b;
            logic [word_size-1:0] d2_a, d2_b;
            always_ff @(posedge i_clk or negedge i_rst_n)
                if (!i_rst_n) begin
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                    d2_a <= '0;
                    d2_b <= '0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) d2_a <= d1_a;
                    if (v1_b) d2_b <= d1_b;
                end
            assign o_valid_A     = v2_a;
            assign o_valid_B     = v2_b;
            assign o_data_read_A = d2_a;
            assign o_data_read_B = d2_b;
        end else begin : g_direct
            assign o_valid_A     = v1_a;
            assign o_valid_B     = v1_b;
            assign o_data_read_A = d1_a;
            assign o_data_read_B = d1_b;
        end
    endgenerate
endmodule

// File: tb/tb_sram_dp_be.sv
// tb_sram_dp_be: drives a 16-word/1-cycle and a 12-word/2-cycle instance with
// shared stimulus and compares both against an array-based reference model.
module tb_sram_dp_be;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        re_a = 1'b0, re_b = 1'b0, we = 1'b0;
    logic [3:0]  ra_a = '0, ra_b = '0, wa = '0, strb = '0;
    logic [31:0] wd = '0;
    logic        rdy [2];
    logic        va [2];
    logic        vb [2];
    logic [31:0] da [2];
    logic [31:0] db [2];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    sram_dp_be #(.word_size(32), .num_words(16), .l2_num_words(4), .out_reg(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy[0]),
        .i_read_enable_A(re_a), .i_addr_read_A(ra_a), .o_data_read_A(da[0]), .o_valid_A(va[0]),
        .i_read_enable_B(re_b), .i_addr_read_B(ra_b), .o_data_read_B(db[0]), .o_valid_B(vb[0]),
        .i_write_enable(we), .i_write_strb(strb), .i_addr_write(wa), .i_data_to_write(wd)
    );

    sram_dp_be #(.word_size(32), .num_words(12), .l2_num_words(4), .out_reg(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy[1]),
        .i_read_enable_A(re_a), .i_addr_read_A(ra_a), .o_data_read_A(da[1]), .o_valid_A(va[1]),
        .i_read_enable_B(re_b), .i_addr_read_B(ra_b), .o_data_read_B(db[1]), .o_valid_B(vb[1]),
        .i_write_enable(we), .i_write_strb(strb), .i_addr_write(wa), .i_data_to_write(wd)
    );

    int          nw [2]  = '{16, 12};
    int          lat [2] = '{0, 1};
    int          cnt [2];
    logic [31:0] mm [2][16];
    logic        er [2];
    logic        ev_a [2];
    logic        ev_b [2];
    logic        pv_a [2];
    logic        pv_b [2];
    logic [31:0] ed_a [2];
    logic [31:0] ed_b [2];
    logic [31:0] pd_a [2];
    logic [31:0] pd_b [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            cnt[c] = 0;
            er[c] = 0; ev_a[c] = 0; ev_b[c] = 0; pv_a[c] = 0; pv_b[c] = 0;
            ed_a[c] = 0; ed_b[c] = 0; pd_a[c] = 0; pd_b[c] = 0;
            for (int i = 0; i < 16; i++) mm[c][i] = 0;
        end
    endtask

    // Word a read of address a returns this edge: 0 out of range, else memory with the write merged in.
    function automatic logic [31:0] model_read(input int c, input logic [3:0] a);
        logic [31:0] r;
        if (int'(a) >= nw[c]) return 32'h0;
        r = mm[c][a];
        if (we && wa == a) r = merge(r, wd, strb);
        return r;
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            logic        acc, rva, rvb;
            logic [31:0] rda, rdb;
            acc = cnt[c] >= nw[c];
            rva = acc && re_a;
            rvb = acc && re_b;
            rda = model_read(c, ra_a);
            rdb = model_read(c, ra_b);
            if (acc && we && int'(wa) < nw[c]) mm[c][wa] = merge(mm[c][wa], wd, strb);
            if (cnt[c] < nw[c]) cnt[c]++;
            er[c] = cnt[c] >= nw[c];
            if (lat[c] == 0) begin
                ev_a[c] = rva;
                ev_b[c] = rvb;
                if (rva) ed_a[c] = rda;
                if (rvb) ed_b[c] = rdb;
            end else begin
                ev_a[c] = pv_a[c];
                ev_b[c] = pv_b[c];
                if (pv_a[c]) ed_a[c] = pd_a[c];
                if (pv_b[c]) ed_b[c] = pd_b[c];
                pv_a[c] = rva; pd_a[c] = rda;
                pv_b[c] = rvb; pd_b[c] = rdb;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("c%0d_ready", c), 32'(rdy[c]), 32'(er[c]));
            chk($sformatf("c%0d_valid_a", c), 32'(va[c]), 32'(ev_a[c]));
            chk($sformatf("c%0d_valid_b", c), 32'(vb[c]), 32'(ev_b[c]));
            chk($sformatf("c%0d_data_a", c), da[c], ed_a[c]);
            chk($sformatf("c%0d_data_b", c), db[c], ed_b[c]);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        re_a = 0; re_b = 0; we = 0;
    endtask

    task automatic rnd();
        re_a = 1'($urandom_range(0, 1));
        re_b = 1'($urandom_range(0, 1));
        we   = 1'($urandom_range(0, 1));
        wa   = 4'($urandom_range(0, 15));
        wd   = $urandom;
        strb = 4'($urandom_range(0, 15));
        ra_a = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
        ra_b = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
    endtask

    // Called at a falling edge; outputs must be zero right after the asynchronous assertion.
    task automatic rst_pulse();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        cyc();
        cyc();
        rst_n = 1;
    endtask

    task automatic clear_and_settle();
        for (int i = 0; i < 11; i++) begin
            rnd();
            cyc();
        end
        idle();
        repeat (5) cyc();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        cyc();
        rst_n = 1;
        clear_and_settle();
        chk("ready_after_16", 32'(rdy[0]), 32'd1);
        for (int i = 0; i < 16; i++) begin
            re_a = 1; ra_a = 4'(i);
            re_b = 1; ra_b = 4'(15 - i);
            cyc();
        end
        idle();
        cyc();
        cyc();
        we = 1; wa = 4'd5; wd = 32'hDEADBEEF; strb = 4'b1111;
        cyc();
        wd = 32'h11223344; strb = 4'b0101;
        cyc();
        idle();
        re_a = 1; ra_a = 4'd5;
        cyc();
        chk("merge_l1_data", da[0], 32'hDE22BE44);
        chk("merge_l1_valid", 32'(va[0]), 32'd1);
        chk("merge_l2_early", 32'(va[1]), 32'd0);
        idle();
        cyc();
        chk("merge_l2_data", da[1], 32'hDE22BE44);
        chk("merge_l2_valid", 32'(va[1]), 32'd1);
        chk("merge_l1_pulse", 32'(va[0]), 32'd0);
        we = 1; wa = 4'd7; wd = 32'hCAFEF00D; strb = 4'b1100;
        re_a = 1; ra_a = 4'd7; re_b = 1; ra_b = 4'd7;
        cyc();
        chk("coll_l1_a", da[0], 32'hCAFE0000);
        chk("coll_l1_b", db[0], 32'hCAFE0000);
        idle();
        cyc();
        chk("coll_l2_a", da[1], 32'hCAFE0000);
        chk("coll_l2_b", db[1], 32'hCAFE0000);
        we = 1; wa = 4'd13; wd = 32'h89ABCDEF; strb = 4'b1111;
        cyc();
        idle();
        re_a = 1; ra_a = 4'd13;
        cyc();
        chk("inrange_13", da[0], 32'h89ABCDEF);
        idle();
        cyc();
        chk("oor_13_data", da[1], 32'h0);
        chk("oor_13_valid", 32'(va[1]), 32'd1);
        repeat (300) begin
            rnd();
            cyc();
        end
        idle();
        re_a = 1; ra_a = 4'd5; re_b = 1; ra_b = 4'd2;
        cyc();
        idle();
        rst_pulse();
        chk("rst_valid_a", 32'(va[1]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            rnd();
            cyc();
        end
        idle();
        rst_pulse();
        clear_and_settle();
        chk("ready_after_restart", 32'(rdy[0]), 32'd1);
        repeat (100) begin
            rnd();
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
